// File: rtl/ipq_pkg.sv
// Shared types and widths for the instruction prefetch queue.
package ipq_pkg;

  localparam int IW = 16;  // instruction word width
  localparam int AW = 16;  // word address width

  typedef enum logic [1:0] {
    FS_IDLE,  // no request outstanding
    FS_BUSY,  // request outstanding, data will be kept
    FS_DROP   // request outstanding, data belongs to a flushed stream
  } fetch_state_t;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } entry_t;

endpackage

// File: rtl/ipq_fifo.sv
// Small circular FIFO of fetched {pc, inst} entries with a registered head.
// The head register keeps its last value when the queue drains or is cleared,
// so the decode-facing outputs hold steady while nothing valid is presented.
module ipq_fifo
  import ipq_pkg::*;
#(
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic          valid,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_after_pop;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;
  entry_t        head_nxt;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // Next occupancy and next head; a push into an empty (or just-emptied) queue
  // becomes the head directly.
  always_comb begin
    count_after_pop = count - CW'(do_pop);
    count_nxt       = count_after_pop + CW'(do_push);
    rd_ptr_nxt      = rd_ptr + PW'(do_pop);
    head_nxt        = (count_after_pop == '0) ? push_data : mem[rd_ptr_nxt];
  end

  // Pointers, occupancy and head register; clear empties the queue but leaves
  // the head value untouched.
  // NOTE: sequential state is always written with <= so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '{pc: RESET_PC, inst: '0};
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (count_nxt != '0) head <= head_nxt;
    end
  end

  // Entry storage.
  // NOTE: the array has no reset; a slot is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: runs ahead of the core fetching sequential words
// from a variable-latency instruction memory (one request outstanding at most),
// buffers them in ipq_fifo and flushes on any non-sequential PC change.
module inst_prefetch_queue
  import ipq_pkg::*;
#(
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [IW-1:0] inst_out,
  output logic [AW-1:0] inst_pc,
  output logic          inst_valid,
  output logic          fetch_stall,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic [AW-1:0] fa;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          push;
  logic          pop;
  logic          can_issue;
  logic          issue;
  entry_t        head;

  // Redirect overrides both ends of the queue; data returning while in
  // FS_DROP belongs to the flushed stream and is never pushed.
  assign push = (state == FS_BUSY) && mem_ack && !redirect;
  assign pop  = advance && inst_valid && !redirect;

  // Occupancy after this edge; any request still on the bus has completed
  // whenever this is consulted, so it alone decides whether room remains.
  assign count_after = count - CW'(pop) + CW'(push);
  assign can_issue   = (count_after < CW'(DEPTH));

  assign issue = !redirect &&
                 (((state == FS_IDLE) && can_issue) ||
                  ((state == FS_BUSY) && mem_ack && can_issue) ||
                  ((state == FS_DROP) && mem_ack));

  ipq_fifo #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC),
    .CW      (CW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (redirect),
    .push     (push),
    .push_data('{pc: mem_addr, inst: mem_rdata}),
    .pop      (pop),
    .head     (head),
    .valid    (inst_valid),
    .count    (count)
  );

  assign inst_out    = head.inst;
  assign inst_pc     = head.pc;
  assign fetch_stall = ~inst_valid;

  // Fetch FSM with fetch pointer and registered memory request; the request
  // and its address hold until mem_ack, even across a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FS_IDLE;
      fa       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      if (redirect) fa <= redirect_pc;
      if (issue) begin
        state    <= FS_BUSY;
        mem_req  <= 1'b1;
        mem_addr <= fa;
        fa       <= fa + AW'(1);
      end else begin
        case (state)
          FS_IDLE: ;
          FS_BUSY: begin
            if (mem_ack) begin
              state   <= FS_IDLE;
              mem_req <= 1'b0;
            end else if (redirect) begin
              state <= FS_DROP;
            end
          end
          FS_DROP: begin
            if (mem_ack) begin
              state   <= FS_IDLE;
              mem_req <= 1'b0;
            end
          end
          default: begin
            state   <= FS_IDLE;
            mem_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue. Memory model returns 16'hA000+addr
// after a programmable number of wait cycles.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        advance;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] inst_out;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        fetch_stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int          lat;
  logic [7:0]  wcnt;
  int          tests  = 0;
  int          failed = 0;
  int          acks;
  logic        found;

  always #5 clk = ~clk;

  inst_prefetch_queue #(
    .DEPTH   (4),
    .RESET_PC(16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .fetch_stall(fetch_stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  // Memory model: ack after 'lat' wait cycles of an open request.
  assign mem_ack   = mem_req && (int'(wcnt) >= lat);
  assign mem_rdata = 16'hA000 + mem_addr;

  always @(posedge clk or negedge rst) begin
    if (!rst)                  wcnt <= '0;
    else if (mem_req && !mem_ack) wcnt <= wcnt + 8'd1;
    else                       wcnt <= '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},     32'(mem_req),     32'd0);
    check({tag, "_mem_addr"},    32'(mem_addr),    32'h0000);
    check({tag, "_inst_valid"},  32'(inst_valid),  32'd0);
    check({tag, "_fetch_stall"}, 32'(fetch_stall), 32'd1);
    check({tag, "_inst_out"},    32'(inst_out),    32'h0000);
    check({tag, "_inst_pc"},     32'(inst_pc),     32'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; advance = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; lat = 0;

    // ---- 1: reset values, then zero-wait streaming with advance=1
    tick(); tick();
    check_reset_outputs("t1_reset");
    rst = 1'b1; advance = 1'b1;                  // cycle 0
    check("t1_c0_mem_req", 32'(mem_req), 32'd0);
    tick();                                      // cycle 1
    check("t1_c1_mem_req",  32'(mem_req),    32'd1);
    check("t1_c1_mem_addr", 32'(mem_addr),   32'h0000);
    check("t1_c1_valid",    32'(inst_valid), 32'd0);
    tick();                                      // cycle 2
    check("t1_c2_valid", 32'(inst_valid), 32'd1);
    check("t1_c2_pc",    32'(inst_pc),    32'h0000);
    check("t1_c2_inst",  32'(inst_out),   32'hA000);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("t1_stream%0d_valid", i), 32'(inst_valid), 32'd1);
      check($sformatf("t1_stream%0d_pc", i),    32'(inst_pc),    32'(i));
      check($sformatf("t1_stream%0d_inst", i),  32'(inst_out),   32'(16'hA000 + 16'(i)));
    end

    // ---- 2: advance held low fills exactly DEPTH entries
    rst = 1'b0; advance = 1'b0;
    tick(); tick();
    rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_req && mem_ack) acks++;
    end
    check("t2_acks",    32'(acks),       32'd4);
    check("t2_mem_req", 32'(mem_req),    32'd0);
    check("t2_valid",   32'(inst_valid), 32'd1);
    check("t2_pc_held", 32'(inst_pc),    32'h0000);
    advance = 1'b1;
    tick();
    advance = 1'b0;
    check("t2_pop_pc",     32'(inst_pc),  32'h0001);
    check("t2_refill_req", 32'(mem_req),  32'd1);
    check("t2_refill_addr",32'(mem_addr), 32'h0004);

    // ---- 3: 3-cycle latency, redirect while addr 5 is outstanding
    rst = 1'b0; advance = 1'b0; lat = 2;
    tick(); tick();
    rst = 1'b1; advance = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (mem_req && mem_addr == 16'h0005) found = 1'b1;
    end
    check("t3_found_addr5", 32'(found), 32'd1);
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    check("t3_drop1_req",   32'(mem_req),    32'd1);
    check("t3_drop1_addr",  32'(mem_addr),   32'h0005);
    check("t3_drop1_ack",   32'(mem_ack),    32'd0);
    check("t3_drop1_valid", 32'(inst_valid), 32'd0);
    tick();
    check("t3_drop2_addr",  32'(mem_addr),   32'h0005);
    check("t3_drop2_ack",   32'(mem_ack),    32'd1);
    check("t3_drop2_valid", 32'(inst_valid), 32'd0);
    tick();
    check("t3_new_req",   32'(mem_req),    32'd1);
    check("t3_new_addr",  32'(mem_addr),   32'h0040);
    check("t3_new_valid", 32'(inst_valid), 32'd0);
    tick();
    check("t3_wait1_valid", 32'(inst_valid), 32'd0);
    tick();
    check("t3_wait2_valid", 32'(inst_valid), 32'd0);
    tick();
    check("t3_first_valid", 32'(inst_valid), 32'd1);
    check("t3_first_pc",    32'(inst_pc),    32'h0040);
    check("t3_first_inst",  32'(inst_out),   32'hA040);

    // ---- 4: redirect coincident with mem_ack and advance
    rst = 1'b0; advance = 1'b0; lat = 0;
    tick(); tick();
    rst = 1'b1; advance = 1'b1;
    tick(); tick(); tick(); tick();              // cycle 4
    check("t4_pre_ack",   32'(mem_ack),    32'd1);
    check("t4_pre_valid", 32'(inst_valid), 32'd1);
    check("t4_pre_pc",    32'(inst_pc),    32'h0002);
    redirect = 1'b1; redirect_pc = 16'h1234;
    tick();
    redirect = 1'b0;
    check("t4_flush_valid", 32'(inst_valid), 32'd0);
    check("t4_no_old_req",  32'(mem_req),    32'd0);
    tick();
    check("t4_new_req",   32'(mem_req),    32'd1);
    check("t4_new_addr",  32'(mem_addr),   32'h1234);
    check("t4_new_valid", 32'(inst_valid), 32'd0);
    tick();
    check("t4_t3_valid", 32'(inst_valid), 32'd1);
    check("t4_t3_pc",    32'(inst_pc),    32'h1234);
    check("t4_t3_inst",  32'(inst_out),   32'hB234);

    // ---- 5: fetch pointer wraps FFFF -> 0000
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    tick();
    check("t5_addr_fffe", 32'(mem_addr), 32'hFFFE);
    tick();
    check("t5_addr_ffff", 32'(mem_addr), 32'hFFFF);
    check("t5_pc_fffe",   32'(inst_pc),  32'hFFFE);
    check("t5_inst_fffe", 32'(inst_out), 32'h9FFE);
    tick();
    check("t5_addr_0000", 32'(mem_addr), 32'h0000);
    check("t5_pc_ffff",   32'(inst_pc),  32'hFFFF);
    check("t5_inst_ffff", 32'(inst_out), 32'h9FFF);
    tick();
    check("t5_addr_0001", 32'(mem_addr), 32'h0001);
    check("t5_pc_0000",   32'(inst_pc),  32'h0000);
    check("t5_inst_0000", 32'(inst_out), 32'hA000);
    tick();
    check("t5_pc_0001", 32'(inst_pc),    32'h0001);
    check("t5_valid",   32'(inst_valid), 32'd1);

    // ---- 6: asynchronous reset while busy with two entries
    rst = 1'b0; advance = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick();                      // cycle 3: 2 entries, req addr 2
    check("t6_pre_valid", 32'(inst_valid), 32'd1);
    check("t6_pre_pc",    32'(inst_pc),    32'h0000);
    check("t6_pre_req",   32'(mem_req),    32'd1);
    check("t6_pre_addr",  32'(mem_addr),   32'h0002);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t6_restart_req",  32'(mem_req),  32'd1);
    check("t6_restart_addr", 32'(mem_addr), 32'h0000);
    tick();
    check("t6_restart_valid", 32'(inst_valid), 32'd1);
    check("t6_restart_pc",    32'(inst_pc),    32'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_queue.md
# inst_prefetch_queue

Instruction prefetch queue between a variable-latency instruction memory and the decode-stage input of the 16-bit pipelined datapath. It fetches sequential words ahead of the core into a small FIFO, presents the head instruction and its PC to the IF/ID register, and flushes on a taken branch, jump, for-loop or RR redirect. When the head is not valid, the hazard unit asserts StallF/StallD.

## Interface
- DEPTH, 4: queue entries, power of two, minimum 2.
- RESET_PC, 16'h0000: first fetch address after reset.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- advance  in  1  core consumes the head this cycle (driven as ~StallF). Ignored when inst_valid=0.
- redirect  in  1  non-sequential PC change. Flushes the queue.
- redirect_pc  in  16  new fetch address; sampled when redirect=1.
- inst_out  out  16  head instruction; feeds inst_in.
- inst_pc  out  16  address of the head instruction.
- inst_valid  out  1  head entry is valid.
- fetch_stall  out  1  equals ~inst_valid; to the hazard unit.
- mem_req  out  1  instruction read request, registered.
- mem_addr  out  16  request address; stable while mem_req=1.
- mem_ack  in  1  request complete; mem_rdata is valid this cycle.
- mem_rdata  in  16  instruction word.

## Operation
- Addressing is word-based. The fetch pointer fa increments by 1 per issued request and wraps from 16'hFFFF to 16'h0000.
- At most one request is outstanding. After mem_req rises, it and mem_addr hold until the cycle in which mem_ack=1. mem_ack while mem_req=0 is ignored.
- Issue rule: a new request issues when count + outstanding < DEPTH.
- State machine (FS_IDLE, FS_BUSY, FS_DROP):
  - FS_IDLE → FS_BUSY on issue: mem_req=1, mem_addr=fa, then fa increments.
  - FS_BUSY with mem_ack: push {mem_addr, mem_rdata}. Go to FS_BUSY if the issue rule still holds (back-to-back request), otherwise FS_IDLE.
  - FS_BUSY with redirect and no mem_ack → FS_DROP. The outstanding request stays on the bus.
  - FS_DROP with mem_ack: discard the data and issue at fa (which already equals redirect_pc) → FS_BUSY.
- Redirect:
  - clears all entries the same cycle and sets fa=redirect_pc.
  - has priority over advance and over push.
  - If mem_ack coincides with redirect, that data is discarded, no FS_DROP is entered, and a request at redirect_pc issues next cycle.
  - redirect while in FS_DROP updates fa again. The last redirect wins.
- Push and pop in the same cycle are both performed, so count is unchanged.
- A pop happens only when inst_valid=1 and advance=1.
- inst_out and inst_pc hold their values while inst_valid=0. They are don't-care for the core.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, inst_valid=0, fetch_stall=1, inst_out=16'h0000, inst_pc=RESET_PC, fa=RESET_PC, state FS_IDLE, count=0.
- The first request (mem_req=1) is visible one cycle after rst deasserts.
- Push at edge t (mem_ack=1 in cycle t−1) gives inst_valid=1 from cycle t. There is no memory-to-output bypass.
- With zero-wait memory (mem_ack in the same cycle as mem_req), the sustained rate is one instruction per cycle.
- Redirect in cycle t: inst_valid=0 from t+1. The earliest valid instruction at redirect_pc appears at t+3 with zero-wait memory and no drop.
- rst asserted mid-operation: all state returns to reset values immediately. The pending request is abandoned, and the memory tolerates this.

## Structure
- Package ipq_pkg holds:
  - typedef fetch_state_t {FS_IDLE, FS_BUSY, FS_DROP};
  - localparams IW=16 and AW=16;
  - entry struct {pc, inst}.
- Sub-module ipq_fifo (DEPTH entries, synchronous push/pop/clear, count output). The FSM, fetch pointer and memory handshake live in inst_prefetch_queue.

## Test plan
- Reset release, memory returns 16'hA000+addr with zero-wait, advance=1:
  - inst_valid rises in cycle 2;
  - then addresses 0,1,2,3,... stream one per cycle with matching inst_pc.
- advance=0 held, memory zero-wait:
  - exactly DEPTH=4 entries are fetched;
  - mem_req=0 afterwards;
  - inst_pc stays 0 until advance=1.
- 3-cycle memory latency, redirect to 16'h0040 while a request for addr 5 is outstanding:
  - mem_addr stays 5 until mem_ack;
  - the addr 5 data never appears;
  - the next mem_addr is 16'h0040.
- redirect coincident with mem_ack and advance:
  - queue empty next cycle;
  - next mem_addr is redirect_pc;
  - no extra request for the old stream.
- redirect_pc=16'hFFFE with zero-wait memory: fetch order is FFFE, FFFF, 0000, 0001.
- rst asserted while in FS_BUSY with 2 entries:
  - outputs return to reset values in the same cycle;
  - fetching restarts at RESET_PC.
